// File: rtl/dma_arbiter.sv
// Four-device round-robin arbiter in front of a single DMA controller.
// Latches the winner's transfer parameters, routes its handshake, and aborts hung transfers via a watchdog.
module dma_arbiter #(
    parameter int ADD_LEN    = 8,
    parameter int DATA_LEN   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_W  = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  dev_rqst,
    input  logic [3:0]                  dev_rd_wr,
    input  logic [4*(FIFO_DEPTH+1)-1:0] dev_num_words,
    input  logic [4*ADD_LEN-1:0]        dev_start_addr,
    input  logic [3:0]                  dev_ack_in,
    input  logic [4*DATA_LEN-1:0]       dev_data_in,
    output logic [3:0]                  dev_grant,
    output logic [3:0]                  dev_dma_ack,
    output logic [3:0]                  dev_end,
    output logic [DATA_LEN-1:0]         dev_data_out,
    output logic                        ctl_rqst,
    output logic [FIFO_DEPTH:0]         ctl_num_words,
    output logic [ADD_LEN-1:0]          ctl_start_addr,
    output logic                        ctl_rd_wr,
    output logic                        ctl_dev_ack,
    output logic [DATA_LEN-1:0]         ctl_dev_in,
    output logic                        ctl_reset,
    input  logic                        ctl_dma_ack,
    input  logic [DATA_LEN-1:0]         ctl_dev_out,
    input  logic                        ctl_end_flag,
    output logic                        timeout_err
);

    localparam int NW = FIFO_DEPTH + 1;
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BUSY,
        RELEASE,
        ABORT
    } state_t;

    state_t               state;
    logic [1:0]           ptr;
    logic [1:0]           g;
    logic [3:0]           grant_q;
    logic [3:0]           end_q;
    logic [TIMEOUT_W-1:0] wd;
    logic                 abort_cnt;

    logic [1:0]           sel;
    logic [1:0]           idx;
    logic                 sel_valid;
    logic                 granted;

    // Scan from the farthest candidate down to ptr+1 so the nearest requester overwrites the rest.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        sel       = ptr;
        idx       = ptr;
        sel_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (dev_rqst[idx]) begin
                sel       = idx;
                sel_valid = 1'b1;
            end
        end
    end

    assign granted   = grant_q[g];
    assign dev_grant = grant_q;
    assign dev_end   = end_q;

    // Data-path routing is combinational so the controller sees the owner's handshake with no added latency.
    always_comb begin
        dev_dma_ack  = '0;
        ctl_dev_ack  = 1'b0;
        ctl_dev_in   = '0;
        dev_data_out = '0;
        if (granted) begin
            dev_dma_ack[g] = ctl_dma_ack;
            ctl_dev_ack    = dev_ack_in[g];
            ctl_dev_in     = dev_data_in[g*DATA_LEN +: DATA_LEN];
            dev_data_out   = ctl_dev_out;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= 2'd3;
            g              <= 2'd0;
            grant_q        <= '0;
            end_q          <= '0;
            wd             <= '0;
            abort_cnt      <= 1'b0;
            ctl_rqst       <= 1'b0;
            ctl_reset      <= 1'b0;
            ctl_num_words  <= '0;
            ctl_start_addr <= '0;
            ctl_rd_wr      <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        g              <= sel;
                        grant_q        <= 4'b0001 << sel;
                        ctl_num_words  <= dev_num_words[sel*NW +: NW];
                        ctl_start_addr <= dev_start_addr[sel*ADD_LEN +: ADD_LEN];
                        ctl_rd_wr      <= dev_rd_wr[sel];
                        ctl_rqst       <= 1'b1;
                        wd             <= '0;
                        state          <= REQ;
                    end
                end

                REQ: begin
                    ctl_rqst <= 1'b0;
                    state    <= BUSY;
                end

                // Completion outranks expiry; any data strobe restarts the watchdog.
                BUSY: begin
                    if (ctl_end_flag) begin
                        end_q <= 4'b0001 << g;
                        state <= RELEASE;
                    end else if (ctl_dma_ack) begin
                        wd <= '0;
                    end else if (wd == WD_MAX - 1'b1) begin
                        wd          <= WD_MAX;
                        grant_q     <= '0;
                        end_q       <= 4'b0001 << g;
                        ctl_reset   <= 1'b1;
                        timeout_err <= 1'b1;
                        abort_cnt   <= 1'b0;
                        state       <= ABORT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end

                RELEASE: begin
                    end_q   <= '0;
                    grant_q <= '0;
                    ptr     <= g;
                    state   <= IDLE;
                end

                // Two cycles of controller reset, counted by abort_cnt.
                ABORT: begin
                    end_q <= '0;
                    if (!abort_cnt) begin
                        abort_cnt <= 1'b1;
                    end else begin
                        abort_cnt <= 1'b0;
                        ctl_reset <= 1'b0;
                        ptr       <= g;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameters SHALL be: ADD_LEN, default 8, address width; DATA_LEN, default 8, data width; FIFO_DEPTH, default 4, word-count width minus 1; TIMEOUT_W, default 12, watchdog width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: clock.
- reset in 1: reset, asynchronous, active-high.
- dev_rqst in 4: per-device transfer request.
- dev_rd_wr in 4: per-device direction (1 = memory read).
- dev_num_words in 4*(FIFO_DEPTH+1): per-device word count, device i at slice i.
- dev_start_addr in 4*ADD_LEN: per-device start address.
- dev_ack_in in 4: per-device data handshake.
- dev_data_in in 4*DATA_LEN: per-device write data.
- dev_grant out 4: one-hot ownership.
- dev_dma_ack out 4: routed data-valid/acquired strobe.
- dev_end out 4: one-cycle completion pulse.
- dev_data_out out DATA_LEN: read data, broadcast.
- ctl_rqst out 1: request to the DMA controller.
- ctl_num_words out FIFO_DEPTH+1: latched count.
- ctl_start_addr out ADD_LEN: latched address.
- ctl_rd_wr out 1: latched direction.
- ctl_dev_ack out 1: routed handshake.
- ctl_dev_in out DATA_LEN: routed write data.
- ctl_reset out 1: controller reset on abort.
- ctl_dma_ack in 1: controller's data strobe.
- ctl_dev_out in DATA_LEN: controller read data.
- ctl_end_flag in 1: controller completion.
- timeout_err out 1: sticky watchdog flag.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, BUSY, RELEASE and ABORT, with a 2-bit round-robin pointer ptr holding the last granted index.
REQ-004 IDLE: if any dev_rqst is high, the block SHALL select the first requester scanning ptr+1, ptr+2, ptr+3, ptr (mod 4), register grant index g, latch that device's num_words/start_addr/rd_wr, and go to REQ; otherwise it SHALL stay in IDLE.
REQ-005 REQ: ctl_rqst SHALL be high for exactly one cycle, followed by an unconditional transition to BUSY.
REQ-006 ctl_num_words, ctl_start_addr and ctl_rd_wr SHALL come from registers and SHALL stay stable from REQ until IDLE is re-entered; requester inputs changing mid-grant SHALL have no effect.
REQ-007 dev_grant[g] SHALL be high in REQ, BUSY and RELEASE, and all dev_grant bits SHALL be 0 in IDLE and ABORT.
REQ-008 While dev_grant[g] is high, the block SHALL drive ctl_dev_ack = dev_ack_in[g], ctl_dev_in = dev_data_in[g] and dev_dma_ack[g] = ctl_dma_ack, all combinational; non-granted dev_dma_ack bits and ctl_dev_ack SHALL be 0 otherwise.
REQ-009 dev_data_out SHALL equal ctl_dev_out when any grant is active, else 0.
REQ-010 BUSY: ctl_end_flag high SHALL cause a transition to RELEASE.
REQ-011 BUSY: a TIMEOUT_W-bit watchdog SHALL clear on REQ entry, increment each BUSY cycle and reset to 0 on every ctl_dma_ack; reaching all-ones SHALL cause a transition to ABORT.
REQ-012 ctl_end_flag SHALL take priority over watchdog expiry in the same cycle.
REQ-013 RELEASE: dev_end[g] SHALL pulse for one cycle, ptr SHALL become g, and the next state SHALL be IDLE.
REQ-014 ABORT: ctl_reset SHALL be high for exactly 2 cycles (internal 1-bit counter).
REQ-015 ABORT: timeout_err SHALL be set, dev_end[g] SHALL pulse on the first ABORT cycle, ptr SHALL become g, and the state SHALL then return to IDLE.
REQ-016 timeout_err SHALL clear only on reset.
REQ-017 A requester whose dev_rqst is still high in IDLE after release SHALL be treated as a new request, with round-robin order preventing starvation (worst-case wait 3 transfers).
REQ-018 ctl_end_flag or ctl_dma_ack arriving in IDLE, REQ or ABORT SHALL be ignored.
REQ-019 dev_rqst deasserting after grant SHALL NOT cancel the transfer.

Reset
REQ-020 Asynchronous reset SHALL force: state IDLE; ptr = 3 (so device 0 is first); all latched registers, the watchdog and timeout_err = 0; every output 0.
REQ-021 Reset asserted mid-transfer SHALL drop the grant immediately, with no dev_end pulse.

Verification
REQ-022 dev_rqst=0110 from reset -> device 1 granted, ctl_rqst 1 cycle later, ctl_start_addr = device 1's address.
REQ-023 All four requesting continuously, each transfer ending via ctl_end_flag -> grant order 0,1,2,3,0; one dev_end pulse per transfer.
REQ-024 Device 2 granted, dev_start_addr[2] changed during BUSY -> ctl_start_addr unchanged; ctl_dev_ack follows dev_ack_in[2] only; dev_dma_ack[0,1,3] stay 0.
REQ-025 BUSY with no ctl_dma_ack for 4095 cycles -> ABORT; ctl_reset high 2 cycles; timeout_err=1; dev_end[g] pulse; next device granted.
REQ-026 ctl_end_flag coincident with watchdog expiry -> RELEASE, timeout_err stays 0.
REQ-027 Reset asserted during BUSY -> dev_grant=0000 in the same cycle; after release, device 0 is served first.
